pdp8l_iop_seq: RTL and testbench



---
 rtl/pdp8l_iop_seq_pkg.sv | 41 ++++
 rtl/pdp8l_sync2.sv | 32 +++
 rtl/pdp8l_iop_seq.sv | 157 +++++++++++++++
 tb/tb_pdp8l_iop_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8l_iop_seq_pkg.sv
// ---------------------------------------------------------------------------
// pdp8l_iop_pkg
// Shared types and constants for the PDP-8/L IOP pulse sequencer:
//   - iop_state_e : sequencer states (IDLE, QUAL, ARMED, ACTIVE)
//   - FILTCYC_DEF : default deglitch length in synchronized cycles
//   - CNT_W       : filter counter width
//   - IOP1/IOP2/IOP4 : one-hot codes in {iop4,iop2,iop1} order
//   - iop_pick()  : priority select iop1 > iop2 > iop4
//   - iop_multi() : true when two or more IOP lines are active together
// ---------------------------------------------------------------------------
package pdp8l_iop_pkg;

    localparam int unsigned FILTCYC_DEF = 5;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUAL   = 2'd1,
        ARMED  = 2'd2,
        ACTIVE = 2'd3
    } iop_state_e;

    localparam logic [2:0] IOP_NONE = 3'b000;
    localparam logic [2:0] IOP1     = 3'b001;
    localparam logic [2:0] IOP2     = 3'b010;
    localparam logic [2:0] IOP4     = 3'b100;

    function automatic logic [2:0] iop_pick(input logic [2:0] act);
        logic [2:0] sel;
        sel = IOP_NONE;
        if (act[0])      sel = IOP1;
        else if (act[1]) sel = IOP2;
        else if (act[2]) sel = IOP4;
        return sel;
    endfunction

    function automatic logic iop_multi(input logic [2:0] act);
        return (act[0] & act[1]) | (act[0] & act[2]) | (act[1] & act[2]);
    endfunction

endpackage

// File: rtl/pdp8l_sync2.sv
// ---------------------------------------------------------------------------
// pdp8l_sync2
// Two-flop synchronizer with asynchronous active-low clear (output clears
// to 0).
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low clear
//   d_i    : asynchronous input
//   q_o    : synchronized output
// ---------------------------------------------------------------------------
module pdp8l_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pdp8l_iop_seq.sv
// ---------------------------------------------------------------------------
// pdp8l_iop_seq
// Synchronizes and deglitches the raw PDP-8/L IOP1/IOP2/IOP4 pulses and
// produces one-cycle iopstart/iopstop strobes with a latched IOT opcode.
//
// Parameters:
//   FILTCYC   : consecutive synchronized cycles a level must hold (1..15)
// Ports:
//   CLOCK     : fabric clock
//   _RESET    : asynchronous active-low reset
//   _iop1/2/4 : raw active-low IOP pulses from the CPU
//   mbin      : CPU memory buffer (IOT instruction during an IOP)
//   armwrite  : ARM register-write strobe; defers iopstart by a cycle
//   nanocycle, nanostep : only with PDP8L_IOP_NANOSTEP_EN defined
//   iopstart  : one-cycle pulse, accepted IOP has begun
//   iopstop   : one-cycle pulse, accepted IOP has ended
//   ioopcode  : mbin latched at acceptance
//   iopsel    : one-hot {iop4,iop2,iop1} of the IOP in progress
//   ioperr    : sticky, two or more IOPs seen at once
//
// Optional feature macro: PDP8L_IOP_NANOSTEP_EN
//   When defined, nanocycle=1 makes the sequencer advance only on cycles
//   where nanostep rises; synchronizers and ioperr always run.
// ---------------------------------------------------------------------------
module pdp8l_iop_seq
    import pdp8l_iop_pkg::*;
#(
    parameter int unsigned FILTCYC = FILTCYC_DEF
) (
    input  logic        CLOCK,
    input  logic        _RESET,
    input  logic        _iop1,
    input  logic        _iop2,
    input  logic        _iop4,
    input  logic [11:0] mbin,
    input  logic        armwrite,
`ifdef PDP8L_IOP_NANOSTEP_EN
    input  logic        nanocycle,
    input  logic        nanostep,
`endif
    output logic        iopstart,
    output logic        iopstop,
    output logic [11:0] ioopcode,
    output logic [2:0]  iopsel,
    output logic        ioperr
);

    localparam logic [CNT_W-1:0] FILT = CNT_W'(FILTCYC);

    // Inverted ahead of the synchronizer so a cleared synchronizer reads as
    // "not asserted"; a line held low across reset is re-qualified from 0.
    logic [2:0] iop_s;

    pdp8l_sync2 u_sync_iop1 (.clk_i(CLOCK), .rst_ni(_RESET), .d_i(~_iop1), .q_o(iop_s[0]));
    pdp8l_sync2 u_sync_iop2 (.clk_i(CLOCK), .rst_ni(_RESET), .d_i(~_iop2), .q_o(iop_s[1]));
    pdp8l_sync2 u_sync_iop4 (.clk_i(CLOCK), .rst_ni(_RESET), .d_i(~_iop4), .q_o(iop_s[2]));

    iop_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       cand_q;
    logic             cand_hit;
    logic             adv;
    logic             iopstart_q;
    logic             iopstop_q;
    logic [11:0]      ioopcode_q;
    logic [2:0]       iopsel_q;
    logic             ioperr_q;

`ifdef PDP8L_IOP_NANOSTEP_EN
    logic nanostep_q;

    always_ff @(posedge CLOCK or negedge _RESET) begin
        if (!_RESET) nanostep_q <= 1'b0;
        else         nanostep_q <= nanostep;
    end

    assign adv = nanocycle ? (nanostep & ~nanostep_q) : 1'b1;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        cand_hit = |(iop_s & cand_q);
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge CLOCK or negedge _RESET) begin
        if (!_RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= IOP_NONE;
            iopstart_q <= 1'b0;
            iopstop_q  <= 1'b0;
            ioopcode_q <= '0;
            iopsel_q   <= IOP_NONE;
            ioperr_q   <= 1'b0;
        end else begin
            iopstart_q <= 1'b0;
            iopstop_q  <= 1'b0;

            if (iop_multi(iop_s)) ioperr_q <= 1'b1;

            if (adv) begin
                unique case (state_q)
                    IDLE: begin
                        if (|iop_s) begin
                            cand_q  <= iop_pick(iop_s);
                            cnt_q   <= CNT_W'(1);
                            state_q <= (FILT <= CNT_W'(1)) ? ARMED : QUAL;
                        end
                    end
                    QUAL: begin
                        if (!cand_hit) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                            if (cnt_d >= FILT) state_q <= ARMED;
                        end
                    end
                    ARMED: begin
                        ioopcode_q <= mbin;
                        iopsel_q   <= cand_q;
                        cnt_q      <= '0;
                        if (!armwrite) begin
                            iopstart_q <= 1'b1;
                            state_q    <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        // The stop strobe fires one cycle after the low count
                        // reaches FILTCYC, mirroring the ARMED cycle on entry.
                        if (cnt_q >= FILT) begin
                            iopstop_q <= 1'b1;
                            iopsel_q  <= IOP_NONE;
                            cnt_q     <= '0;
                            state_q   <= IDLE;
                        end else if (cand_hit) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign iopstart = iopstart_q;
    assign iopstop  = iopstop_q;
    assign ioopcode = ioopcode_q;
    assign iopsel   = iopsel_q;
    assign ioperr   = ioperr_q;

endmodule

// File: tb/tb_pdp8l_iop_seq.sv
// ---------------------------------------------------------------------------
// tb_pdp8l_iop_seq
// Directed self-checking bench for pdp8l_iop_seq with FILTCYC=5.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// Latencies are counted in rising edges from the input change to the first
// edge after which the strobe is visible.
// ---------------------------------------------------------------------------
module tb_pdp8l_iop_seq;
    import pdp8l_iop_pkg::*;

    logic        CLOCK = 1'b0;
    logic        _RESET;
    logic        _iop1, _iop2, _iop4;
    logic [11:0] mbin;
    logic        armwrite;
    logic        iopstart, iopstop, ioperr;
    logic [11:0] ioopcode;
    logic [2:0]  iopsel;
`ifdef PDP8L_IOP_NANOSTEP_EN
    logic        nanocycle;
    logic        nanostep;
`endif

    int npass  = 0;
    int ntotal = 0;
    int nstart = 0;
    int nstop  = 0;
    int nboth  = 0;
    int n;

    pdp8l_iop_seq #(.FILTCYC(5)) dut (
        .CLOCK    (CLOCK),
        ._RESET   (_RESET),
        ._iop1    (_iop1),
        ._iop2    (_iop2),
        ._iop4    (_iop4),
        .mbin     (mbin),
        .armwrite (armwrite),
`ifdef PDP8L_IOP_NANOSTEP_EN
        .nanocycle(nanocycle),
        .nanostep (nanostep),
`endif
        .iopstart (iopstart),
        .iopstop  (iopstop),
        .ioopcode (ioopcode),
        .iopsel   (iopsel),
        .ioperr   (ioperr)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge CLOCK);
        #1;
        if (iopstart) nstart++;
        if (iopstop) nstop++;
        if (iopstart && iopstop) nboth++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_start(input int maxc, output int cnt);
        int s;
        s   = nstart;
        cnt = 0;
        while (nstart == s && cnt <= maxc) begin
            cycle();
            cnt++;
        end
    endtask

    task automatic wait_stop(input int maxc, output int cnt);
        int s;
        s   = nstop;
        cnt = 0;
        while (nstop == s && cnt <= maxc) begin
            cycle();
            cnt++;
        end
    endtask

    initial begin
        _RESET   = 1'b0;
        _iop1    = 1'b1;
        _iop2    = 1'b1;
        _iop4    = 1'b1;
        mbin     = '0;
        armwrite = 1'b0;
`ifdef PDP8L_IOP_NANOSTEP_EN
        nanocycle = 1'b0;
        nanostep  = 1'b0;
`endif
        repeat (2) @(posedge CLOCK);
        #1;

        // Reset state
        check("rst iopstart", 32'(iopstart), 32'd0);
        check("rst iopstop", 32'(iopstop), 32'd0);
        check("rst ioopcode", 32'(ioopcode), 32'd0);
        check("rst iopsel", 32'(iopsel), 32'd0);
        check("rst ioperr", 32'(ioperr), 32'd0);
        check("rst state", 32'(dut.state_q), 32'(IDLE));

        _RESET = 1'b1;
        repeat (3) cycle();

        // IOP2 held low for 30 cycles
        mbin  = 12'o6212;
        _iop2 = 1'b0;
        wait_start(20, n);
        check("iop2 start latency", 32'(n), 32'd8);
        check("iop2 ioopcode", 32'(ioopcode), 32'(12'o6212));
        check("iop2 iopsel", 32'(iopsel), 32'(3'b010));
        cycle();
        check("iop2 start width", 32'(iopstart), 32'd0);
        repeat (21) cycle();
        check("iop2 single start", 32'(nstart), 32'd1);
        _iop2 = 1'b1;
        wait_stop(20, n);
        check("iop2 stop latency", 32'(n), 32'd8);
        check("iop2 iopsel idle", 32'(iopsel), 32'd0);
        cycle();
        check("iop2 stop width", 32'(iopstop), 32'd0);
        check("iop2 ioperr", 32'(ioperr), 32'd0);

        // 3-cycle glitch on IOP1
        mbin  = 12'o7777;
        _iop1 = 1'b0;
        repeat (3) cycle();
        _iop1 = 1'b1;
        check("glitch3 in qual", 32'(dut.state_q), 32'(QUAL));
        repeat (12) cycle();
        check("glitch3 no start", 32'(nstart), 32'd1);
        check("glitch3 state", 32'(dut.state_q), 32'(IDLE));
        check("glitch3 ioopcode", 32'(ioopcode), 32'(12'o6212));
        check("glitch3 iopsel", 32'(iopsel), 32'd0);

        // 4-cycle glitch on IOP4: one short of FILTCYC
        _iop4 = 1'b0;
        repeat (4) cycle();
        _iop4 = 1'b1;
        repeat (12) cycle();
        check("glitch4 no start", 32'(nstart), 32'd1);
        check("glitch4 ioopcode", 32'(ioopcode), 32'(12'o6212));

        // armwrite on the due cycle and the one after
        mbin  = 12'o6001;
        _iop1 = 1'b0;
        repeat (7) cycle();
        check("aw armed", 32'(dut.state_q), 32'(ARMED));
        armwrite = 1'b1;
        cycle();
        check("aw defer1", 32'(iopstart), 32'd0);
        cycle();
        check("aw defer2", 32'(iopstart), 32'd0);
        check("aw still armed", 32'(dut.state_q), 32'(ARMED));
        armwrite = 1'b0;
        cycle();
        check("aw late start", 32'(iopstart), 32'd1);
        check("aw ioopcode", 32'(ioopcode), 32'(12'o6001));
        check("aw iopsel", 32'(iopsel), 32'(3'b001));
        cycle();
        check("aw start width", 32'(iopstart), 32'd0);
        _iop1 = 1'b1;
        wait_stop(20, n);
        check("aw stop latency", 32'(n), 32'd8);
        check("aw start count", 32'(nstart), 32'd2);

        // IOP1 and IOP4 together
        mbin  = 12'o6004;
        _iop1 = 1'b0;
        _iop4 = 1'b0;
        wait_start(20, n);
        check("dual start latency", 32'(n), 32'd8);
        check("dual iopsel", 32'(iopsel), 32'(3'b001));
        check("dual ioperr", 32'(ioperr), 32'd1);
        check("dual ioopcode", 32'(ioopcode), 32'(12'o6004));
        _iop1 = 1'b1;
        _iop4 = 1'b1;
        wait_stop(20, n);
        check("dual stop latency", 32'(n), 32'd8);
        check("dual ioperr sticky", 32'(ioperr), 32'd1);
        check("dual iopsel idle", 32'(iopsel), 32'd0);

        // Reset during ACTIVE with IOP4 held low
        mbin  = 12'o6040;
        _iop4 = 1'b0;
        wait_start(20, n);
        check("rstmid start latency", 32'(n), 32'd8);
        check("rstmid iopsel", 32'(iopsel), 32'(3'b100));
        repeat (3) cycle();
        _RESET = 1'b0;
        #1;
        check("rstmid iopsel0", 32'(iopsel), 32'd0);
        check("rstmid ioopcode0", 32'(ioopcode), 32'd0);
        check("rstmid ioperr0", 32'(ioperr), 32'd0);
        check("rstmid state", 32'(dut.state_q), 32'(IDLE));
        check("rstmid strobes0", 32'({iopstart, iopstop}), 32'd0);
        repeat (2) cycle();
        _RESET = 1'b1;
        wait_start(20, n);
        check("rstmid requal latency", 32'(n), 32'd8);
        check("rstmid requal iopsel", 32'(iopsel), 32'(3'b100));
        check("rstmid requal ioopcode", 32'(ioopcode), 32'(12'o6040));
        _iop4 = 1'b1;
        wait_stop(20, n);
        check("rstmid stop latency", 32'(n), 32'd8);

`ifdef PDP8L_IOP_NANOSTEP_EN
        begin
            int rises;
            int s;
            nanocycle = 1'b1;
            nanostep  = 1'b0;
            mbin      = 12'o6100;
            _iop1     = 1'b0;
            repeat (10) cycle();
            check("nano hold idle", 32'(dut.state_q), 32'(IDLE));
            rises = 0;
            s     = nstart;
            while (nstart == s && rises < 12) begin
                nanostep = 1'b1;
                cycle();
                nanostep = 1'b0;
                rises++;
                if (nstart == s) repeat (9) cycle();
            end
            check("nano start rises", 32'(rises), 32'd6);
            repeat (9) cycle();
            check("nano start width", 32'(nstart - s), 32'd1);
            _iop1 = 1'b1;
            repeat (10) cycle();
            rises = 0;
            s     = nstop;
            while (nstop == s && rises < 12) begin
                nanostep = 1'b1;
                cycle();
                nanostep = 1'b0;
                rises++;
                if (nstop == s) repeat (9) cycle();
            end
            check("nano stop rises", 32'(rises), 32'd6);
            repeat (9) cycle();
            check("nano stop width", 32'(nstop - s), 32'd1);
            nanocycle = 1'b0;
        end
`endif

        repeat (5) cycle();
        check("never both strobes", 32'(nboth), 32'd0);
`ifdef PDP8L_IOP_NANOSTEP_EN
        check("total starts", 32'(nstart), 32'd6);
        check("total stops", 32'(nstop), 32'd5);
`else
        check("total starts", 32'(nstart), 32'd5);
        check("total stops", 32'(nstop), 32'd4);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
